// File: rtl/ignition_seq_pkg.sv
// rtl/ignition_seq_pkg.sv - state encodings and shared constants for the ignition event sequencer
package ignition_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ARMED   = 3'd1,
    ST_IGNITE  = 3'd2,
    ST_PLATEAU = 3'd3,
    ST_REFRACT = 3'd4
  } state_t;

  localparam int Q14_FRAC     = 14;
  localparam int Q14_ONE      = 1 << Q14_FRAC;
  localparam int Q14_HALF     = 1 << (Q14_FRAC - 1);
  localparam int HYST_DEFAULT = 819;

  localparam int EV_ALIGN_W = 18;
  localparam int EV_PLAT_W  = 12;

endpackage

// File: rtl/event_skid_reg.sv
// rtl/event_skid_reg.sv - single-entry valid/ready event holding register with sticky drop flag
module event_skid_reg
  import ignition_seq_pkg::*;
#(
  parameter int A_W = EV_ALIGN_W,
  parameter int P_W = EV_PLAT_W
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           push,
  input  logic [A_W-1:0] push_alignment,
  input  logic           push_conscious,
  input  logic [P_W-1:0] push_plateau_len,
  input  logic           ready,
  output logic           valid,
  output logic [A_W-1:0] alignment,
  output logic           conscious,
  output logic [P_W-1:0] plateau_len,
  output logic           overflow
);

  logic consume;
  assign consume = valid && ready;

  // A push lands if the slot is empty or drains on this same edge; otherwise the new record is lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid       <= 1'b0;
      alignment   <= '0;
      conscious   <= 1'b0;
      plateau_len <= '0;
      overflow    <= 1'b0;
    end else if (push && (!valid || consume)) begin
      valid       <= 1'b1;
      alignment   <= push_alignment;
      conscious   <= push_conscious;
      plateau_len <= push_plateau_len;
    end else if (push) begin
      overflow <= 1'b1;
    end else if (consume) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/ignition_event_sequencer.sv
// rtl/ignition_event_sequencer.sv - ignition episode FSM emitting one event record per ignition
// Optional live statistics counters: IGNITION_SEQ_STATS_EN.
module ignition_event_sequencer
  import ignition_seq_pkg::*;
#(
  parameter int WIDTH          = 18,
  parameter int FRAC           = 14,
  parameter int CNT_W          = 12,
  parameter int ARM_CYCLES     = 4,
  parameter int MAX_PLATEAU    = 1024,
  parameter int REFRACT_CYCLES = 256,
  parameter int HYST           = HYST_DEFAULT
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clk_en,
  input  logic signed [WIDTH-1:0] coherence,
  input  logic signed [WIDTH-1:0] ignition_threshold,
  input  logic signed [WIDTH-1:0] overall_alignment,
  input  logic                    ignition_permitted,
  input  logic                    consciousness_access_possible,
  output logic [2:0]              state,
  output logic                    ignition_pulse,
  output logic                    in_ignition,
  output logic                    event_valid,
  input  logic                    event_ready,
  output logic signed [WIDTH-1:0] event_alignment,
  output logic                    event_conscious,
  output logic [CNT_W-1:0]        event_plateau_len,
  output logic                    event_overflow,
  output logic [15:0]             ignition_count,
  output logic [15:0]             abort_count
);

  localparam int ARM_W = $clog2(ARM_CYCLES + 1);
  localparam int WP1   = WIDTH + 1;
  // HYST is a Q14 constant; rescale it when the datapath uses a different fraction.
  localparam int HYST_S = (FRAC >= Q14_FRAC) ? (HYST << (FRAC - Q14_FRAC))
                                             : (HYST >> (Q14_FRAC - FRAC));
  localparam logic signed [WIDTH:0] HYST_W    = WP1'(HYST_S);
  localparam logic [ARM_W-1:0]      ARM_LAST  = ARM_W'(ARM_CYCLES);
  localparam logic [CNT_W-1:0]      PLAT_LAST = CNT_W'(MAX_PLATEAU - 1);
  localparam logic [CNT_W-1:0]      REF_INIT  = CNT_W'(REFRACT_CYCLES);

  state_t                  st_q;
  logic [ARM_W-1:0]        arm_cnt, arm_nxt;
  logic [CNT_W-1:0]        plat_cnt, plat_nxt, ref_cnt, ref_nxt;
  logic signed [WIDTH-1:0] align_lat;
  logic                    consc_lat;
  logic                    pulse_q;
  logic signed [WIDTH:0]   coh_x, thr_x, exit_th;
  logic                    coh_ge_thr, plat_exit, armed_tick;
  logic                    ignite_fire, abort_fire, push;

  assign coh_x      = $signed({coherence[WIDTH-1], coherence});
  assign thr_x      = $signed({ignition_threshold[WIDTH-1], ignition_threshold});
  assign exit_th    = thr_x - HYST_W;
  assign coh_ge_thr = coherence >= ignition_threshold;
  assign plat_exit  = (coh_x < exit_th) || (plat_cnt == PLAT_LAST);

  assign arm_nxt  = arm_cnt + 1'b1;
  assign plat_nxt = plat_cnt + 1'b1;
  assign ref_nxt  = ref_cnt - 1'b1;

  // Abort takes priority over a completing arm on the same tick.
  assign armed_tick  = clk_en && (st_q == ST_ARMED);
  assign abort_fire  = armed_tick && !ignition_permitted;
  assign ignite_fire = armed_tick && ignition_permitted && coh_ge_thr && (arm_nxt == ARM_LAST);
  assign push        = clk_en && (st_q == ST_PLATEAU) && plat_exit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q      <= ST_IDLE;
      arm_cnt   <= '0;
      plat_cnt  <= '0;
      ref_cnt   <= '0;
      align_lat <= '0;
      consc_lat <= 1'b0;
      pulse_q   <= 1'b0;
    end else begin
      pulse_q <= 1'b0;
      if (clk_en) begin
        case (st_q)
          ST_IDLE: begin
            if (ignition_permitted) begin
              st_q    <= ST_ARMED;
              arm_cnt <= '0;
            end
          end
          ST_ARMED: begin
            if (abort_fire) begin
              st_q <= ST_IDLE;
            end else if (ignite_fire) begin
              st_q      <= ST_IGNITE;
              pulse_q   <= 1'b1;
              align_lat <= overall_alignment;
              consc_lat <= consciousness_access_possible;
            end else if (coh_ge_thr) begin
              arm_cnt <= arm_nxt;
            end else begin
              arm_cnt <= '0;
            end
          end
          ST_IGNITE: begin
            plat_cnt <= '0;
            st_q     <= ST_PLATEAU;
          end
          ST_PLATEAU: begin
            if (plat_exit) begin
              st_q    <= ST_REFRACT;
              ref_cnt <= REF_INIT;
            end else begin
              plat_cnt <= plat_nxt;
            end
          end
          ST_REFRACT: begin
            ref_cnt <= ref_nxt;
            if (ref_nxt == '0) st_q <= ST_IDLE;
          end
          default: st_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign state          = st_q;
  assign ignition_pulse = pulse_q;
  assign in_ignition    = (st_q == ST_IGNITE) || (st_q == ST_PLATEAU);

  event_skid_reg #(
    .A_W(WIDTH),
    .P_W(CNT_W)
  ) u_event (
    .clk             (clk),
    .rst_n           (rst_n),
    .push            (push),
    .push_alignment  (align_lat),
    .push_conscious  (consc_lat),
    .push_plateau_len(plat_nxt),
    .ready           (event_ready),
    .valid           (event_valid),
    .alignment       (event_alignment),
    .conscious       (event_conscious),
    .plateau_len     (event_plateau_len),
    .overflow        (event_overflow)
  );

`ifdef IGNITION_SEQ_STATS_EN
  logic [15:0] ign_q, abort_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ign_q   <= '0;
      abort_q <= '0;
    end else begin
      if (ignite_fire && (ign_q != 16'hFFFF)) ign_q <= ign_q + 16'd1;
      if (abort_fire && (abort_q != 16'hFFFF)) abort_q <= abort_q + 16'd1;
    end
  end

  assign ignition_count = ign_q;
  assign abort_count    = abort_q;
`else
  assign ignition_count = '0;
  assign abort_count    = '0;
`endif

endmodule

// File: tb/tb_ignition_event_sequencer.sv
// tb/tb_ignition_event_sequencer.sv - directed plus randomized bench with a tick-level episode model
module tb_ignition_event_sequencer;

  localparam int W    = 18;
  localparam int CW   = 12;
  localparam int ARM  = 4;
  localparam int MAXP = 1024;
  localparam int REFC = 256;
  localparam int HYST = 819;
`ifdef IGNITION_SEQ_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                clk_en = 1'b1;
  logic signed [W-1:0] coherence = '0;
  logic signed [W-1:0] ignition_threshold = '0;
  logic signed [W-1:0] overall_alignment = '0;
  logic                ignition_permitted = 1'b0;
  logic                consciousness_access_possible = 1'b0;
  logic                event_ready = 1'b1;
  logic [2:0]          state;
  logic                ignition_pulse, in_ignition, event_valid, event_conscious, event_overflow;
  logic signed [W-1:0] event_alignment;
  logic [CW-1:0]       event_plateau_len;
  logic [15:0]         ignition_count, abort_count;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ignition_event_sequencer dut (
    .clk                          (clk),
    .rst_n                        (rst_n),
    .clk_en                       (clk_en),
    .coherence                    (coherence),
    .ignition_threshold           (ignition_threshold),
    .overall_alignment            (overall_alignment),
    .ignition_permitted           (ignition_permitted),
    .consciousness_access_possible(consciousness_access_possible),
    .state                        (state),
    .ignition_pulse               (ignition_pulse),
    .in_ignition                  (in_ignition),
    .event_valid                  (event_valid),
    .event_ready                  (event_ready),
    .event_alignment              (event_alignment),
    .event_conscious              (event_conscious),
    .event_plateau_len            (event_plateau_len),
    .event_overflow               (event_overflow),
    .ignition_count               (ignition_count),
    .abort_count                  (abort_count)
  );

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d @%0t", name, act, exp, $time);
    end
  endtask

  // Episode model: phase numbers are the externally visible state codes.
  int m_phase, m_streak, m_dwell, m_left, m_ign, m_abort;
  int m_align_lat, m_ev_align, m_ev_len;
  bit m_pulse, m_consc_lat, m_ev_valid, m_ev_consc, m_ovf;

  always @(posedge clk or negedge rst_n) begin : model
    bit consumed, pushed;
    int len;
    if (!rst_n) begin
      m_phase = 0; m_streak = 0; m_dwell = 0; m_left = 0; m_ign = 0; m_abort = 0;
      m_align_lat = 0; m_ev_align = 0; m_ev_len = 0;
      m_pulse = 0; m_consc_lat = 0; m_ev_valid = 0; m_ev_consc = 0; m_ovf = 0;
    end else begin
      consumed = m_ev_valid && event_ready;
      pushed = 0;
      len = 0;
      m_pulse = 0;
      if (clk_en) begin
        case (m_phase)
          0: if (ignition_permitted) begin m_phase = 1; m_streak = 0; end
          1: begin
            if (!ignition_permitted) begin
              m_phase = 0;
              if (m_abort < 65535) m_abort++;
            end else if (int'(coherence) >= int'(ignition_threshold)) begin
              m_streak++;
              if (m_streak == ARM) begin
                m_phase = 2;
                m_pulse = 1;
                m_align_lat = int'(overall_alignment);
                m_consc_lat = consciousness_access_possible;
                if (m_ign < 65535) m_ign++;
              end
            end else begin
              m_streak = 0;
            end
          end
          2: begin m_phase = 3; m_dwell = 0; end
          3: begin
            m_dwell++;
            if ((int'(coherence) < int'(ignition_threshold) - HYST) || (m_dwell == MAXP)) begin
              m_phase = 4;
              m_left = REFC;
              pushed = 1;
              len = m_dwell;
            end
          end
          default: begin
            m_left--;
            if (m_left == 0) m_phase = 0;
          end
        endcase
      end
      if (pushed) begin
        if (!m_ev_valid || consumed) begin
          m_ev_valid = 1;
          m_ev_align = m_align_lat;
          m_ev_consc = m_consc_lat;
          m_ev_len = len;
        end else begin
          m_ovf = 1;
        end
      end else if (consumed) begin
        m_ev_valid = 0;
      end
    end
  end

  always @(negedge clk) begin
    check("state", state, m_phase);
    check("ignition_pulse", ignition_pulse, m_pulse);
    check("in_ignition", in_ignition, (m_phase == 2 || m_phase == 3) ? 1 : 0);
    check("event_valid", event_valid, m_ev_valid);
    check("event_overflow", event_overflow, m_ovf);
    if (m_ev_valid) begin
      check("event_alignment", event_alignment, m_ev_align);
      check("event_conscious", event_conscious, m_ev_consc);
      check("event_plateau_len", event_plateau_len, m_ev_len);
    end
    check("ignition_count", ignition_count, STATS ? m_ign : 0);
    check("abort_count", abort_count, STATS ? m_abort : 0);
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Full episode ending on coherence after plen plateau ticks; record left to the caller.
  task automatic episode(input int align, input int plen);
    ignition_threshold = 18'sd8000;
    coherence = 18'sd9000;
    overall_alignment = 18'(align);
    ignition_permitted = 1'b1;
    step(1 + ARM);
    step(1);
    step(plen - 1);
    coherence = '0;
    ignition_permitted = 1'b0;
    step(1);
    step(REFC);
  endtask

  initial begin : stim
    int t, c;
    step(3);
    @(negedge clk);
    check("rst_state", state, 0);
    check("rst_valid", event_valid, 0);
    step(1);
    rst_n = 1'b1;

    // Straight ignition, plateau hold at 7500, exit at 7100
    ignition_threshold = 18'sd8000;
    coherence = 18'sd9000;
    overall_alignment = 18'sd1234;
    consciousness_access_possible = 1'b1;
    ignition_permitted = 1'b1;
    step(1);
    @(negedge clk); check("t1_armed", state, 1);
    step(3);
    @(negedge clk); check("t1_still_armed", state, 1); check("t1_no_pulse", ignition_pulse, 0);
    step(1);
    @(negedge clk); check("t1_ignite", state, 2); check("t1_pulse", ignition_pulse, 1);
    step(1);
    @(negedge clk); check("t1_plateau", state, 3); check("t1_pulse_off", ignition_pulse, 0);
    coherence = 18'sd7500;
    step(9);
    @(negedge clk); check("t3_hold", state, 3);
    coherence = 18'sd7100;
    ignition_permitted = 1'b0;
    step(1);
    @(negedge clk);
    check("t3_refract", state, 4);
    check("t3_valid", event_valid, 1);
    check("t3_len", event_plateau_len, 10);
    check("t3_align", event_alignment, 1234);
    check("t3_conscious", event_conscious, 1);
    step(1);
    @(negedge clk); check("t3_consumed", event_valid, 0);
    step(254);
    @(negedge clk); check("t3_refract_end", state, 4);
    step(1);
    @(negedge clk); check("t3_idle", state, 0);

    // Arming dip resets the streak
    overall_alignment = -18'sd500;
    consciousness_access_possible = 1'b0;
    coherence = 18'sd9000;
    ignition_permitted = 1'b1;
    step(3);
    coherence = 18'sd7000;
    step(1);
    coherence = 18'sd9000;
    step(3);
    @(negedge clk); check("t2_armed", state, 1); check("t2_no_pulse", ignition_pulse, 0);
    step(1);
    @(negedge clk); check("t2_pulse", ignition_pulse, 1);
    coherence = -18'sd20000;
    ignition_permitted = 1'b0;
    step(2);
    @(negedge clk); check("t2_len1", event_plateau_len, 1);
    step(REFC);

    // Back-pressure over two episodes
    event_ready = 1'b0;
    episode(111, 3);
    episode(222, 5);
    @(negedge clk);
    check("t4_held_align", event_alignment, 111);
    check("t4_held_len", event_plateau_len, 3);
    check("t4_overflow", event_overflow, 1);
    event_ready = 1'b1;
    step(1);
    @(negedge clk); check("t4_consumed", event_valid, 0);

    // Permission drop on arm completion
    coherence = 18'sd9000;
    ignition_permitted = 1'b1;
    step(4);
    ignition_permitted = 1'b0;
    step(1);
    @(negedge clk);
    check("t5_idle", state, 0);
    check("t5_no_pulse", ignition_pulse, 0);
    check("t5_abort", abort_count, STATS ? 1 : 0);

    // Plateau timeout with permission gone
    ignition_permitted = 1'b1;
    step(5);
    step(1);
    ignition_permitted = 1'b0;
    step(MAXP - 1);
    @(negedge clk); check("t7_still_plateau", state, 3);
    step(1);
    @(negedge clk); check("t7_timeout", state, 4); check("t7_len", event_plateau_len, MAXP);
    step(REFC);

    // Reset mid-plateau with a record held
    event_ready = 1'b0;
    episode(333, 2);
    coherence = 18'sd9000;
    ignition_permitted = 1'b1;
    step(6);
    step(2);
    @(negedge clk); check("t6_pre_state", state, 3); check("t6_pre_valid", event_valid, 1);
    step(1);
    rst_n = 1'b0;
    #1;
    check("t6_state", state, 0);
    check("t6_valid", event_valid, 0);
    check("t6_in_ign", in_ignition, 0);
    check("t6_pulse", ignition_pulse, 0);
    check("t6_align", event_alignment, 0);
    check("t6_len", event_plateau_len, 0);
    check("t6_ovf", event_overflow, 0);
    ignition_permitted = 1'b0;
    step(2);
    rst_n = 1'b1;
    step(10);
    @(negedge clk); check("t6_after_state", state, 0); check("t6_after_pulse", ignition_pulse, 0);

    // Randomized traffic
    t = 8000;
    for (int i = 0; i < 12000; i++) begin
      if ($urandom_range(0, 39) == 0) ignition_permitted = ~ignition_permitted;
      if ($urandom_range(0, 199) == 0) begin
        case ($urandom_range(0, 7))
          0: t = -131072 + 50;
          1: t = 131000;
          default: t = int'($urandom_range(0, 40000)) - 20000;
        endcase
      end
      c = t + int'($urandom_range(0, 2700)) - 1200;
      if (c > 131071) c = 131071;
      if (c < -131072) c = -131072;
      ignition_threshold = 18'(t);
      coherence = 18'(c);
      overall_alignment = 18'($urandom);
      consciousness_access_possible = 1'($urandom);
      clk_en = ($urandom_range(0, 3) != 0);
      event_ready = ($urandom_range(0, 2) == 0);
      step(1);
    end

    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
